xor_nn_core: RTL and testbench



---
 rtl/xor_nn_pkg.sv | 49 ++++
 rtl/xor_nn_if.sv | 12 +
 rtl/xor_nn_sigmoid.sv | 48 ++++
 rtl/xor_nn_core.sv | 56 +++++
 tb/tb_xor_nn_core.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/xor_nn_pkg.sv
// Shared constants and arithmetic helpers for the fixed-point XOR classifier.
// Activations are signed Q6.10; neuron sums are widened to SW bits before saturation.
package xor_nn_pkg;

  localparam int DW      = 16;
  localparam int FRAC    = 10;
  localparam int ONE     = 1 << FRAC;
  localparam int SW      = 24;
  localparam int SAT_LIM = 32767;

  // Weight magnitude 20 is realised as (v << 4) + (v << 2).
  localparam int W_SH_HI = 4;
  localparam int W_SH_LO = 2;
  localparam int BH1     = -10;
  localparam int BH2     = 30;
  localparam int BO      = -30;

  localparam logic signed [SW-1:0] BH1_Q     = SW'(BH1 * ONE);
  localparam logic signed [SW-1:0] BH2_Q     = SW'(BH2 * ONE);
  localparam logic signed [SW-1:0] BO_Q      = SW'(BO * ONE);
  localparam logic signed [SW-1:0] SAT_MAX_S = SW'(SAT_LIM);
  localparam logic signed [SW-1:0] SAT_MIN_S = SW'(-SAT_LIM);

  localparam logic [DW:0]   SIG_BP_LO   = 17'd1024;
  localparam logic [DW:0]   SIG_BP_MID  = 17'd2432;
  localparam logic [DW:0]   SIG_BP_HI   = 17'd5120;
  localparam logic [DW-1:0] SIG_OFF_LO  = 16'd512;
  localparam logic [DW-1:0] SIG_OFF_MID = 16'd640;
  localparam logic [DW-1:0] SIG_OFF_HI  = 16'd864;
  localparam logic [DW-1:0] SIG_ONE     = 16'd1024;
  localparam logic [DW-1:0] CL_THRESH   = 16'd512;

  function automatic logic signed [SW-1:0] mul_w(input logic signed [SW-1:0] v);
    return (v <<< W_SH_HI) + (v <<< W_SH_LO);
  endfunction

  function automatic logic signed [DW-1:0] sat_q(input logic signed [SW-1:0] v);
    logic signed [DW-1:0] r;
    if (v > SAT_MAX_S) begin
      r = SAT_MAX_S[DW-1:0];
    end else if (v < SAT_MIN_S) begin
      r = SAT_MIN_S[DW-1:0];
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/xor_nn_if.sv
// Sample/class bus of the XOR classifier: enable plus two Q6.10 inputs in, class bit out.
interface xor_nn_if;
  import xor_nn_pkg::*;

  logic                 en;
  logic signed [DW-1:0] x1;
  logic signed [DW-1:0] x2;
  logic                 cl;

  modport master (output en, output x1, output x2, input cl);
  modport slave  (input en, input x1, input x2, output cl);
endinterface

// File: rtl/xor_nn_sigmoid.sv
// Registered PLAN piecewise-linear sigmoid: signed Q6.10 in, unsigned Q6.10 in [0, 1024] out.
module nn_sigmoid
  import xor_nn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] x,
  output logic        [DW-1:0] y
);

  logic          neg_s;
  logic [DW:0]   a_s;
  logic [DW-1:0] f_s;
  logic [DW-1:0] y_d;
  logic [DW-1:0] y_q;

  // Magnitude is one bit wider so that -32768 cannot wrap.
  always_comb begin
    neg_s = x[DW-1];
    a_s   = neg_s ? (17'd0 - {x[DW-1], x}) : {1'b0, x};
    if (a_s >= SIG_BP_HI) begin
      f_s = SIG_ONE;
    end else if (a_s >= SIG_BP_MID) begin
      f_s = DW'(a_s >> 5) + SIG_OFF_HI;
    end else if (a_s >= SIG_BP_LO) begin
      f_s = DW'(a_s >> 3) + SIG_OFF_MID;
    end else begin
      f_s = DW'(a_s >> 2) + SIG_OFF_LO;
    end
    if (en) begin
      y_d = neg_s ? (SIG_ONE - f_s) : f_s;
    end else begin
      y_d = y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= 16'd0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/xor_nn_core.sv
// Five-stage 2-2-1 fixed-point network (OR/NAND hidden, AND output) classifying XOR.
// Stages: hidden sums, hidden sigmoids, output sum, output sigmoid, threshold.
module xor_nn_core
  import xor_nn_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  xor_nn_if.slave  bus
);

  logic signed [SW-1:0] xw_s;
  logic signed [SW-1:0] hw_s;
  logic signed [DW-1:0] zh1_d, zh1_q;
  logic signed [DW-1:0] zh2_d, zh2_q;
  logic signed [DW-1:0] zo_d, zo_q;
  logic        [DW-1:0] h1_s, h2_s, y_s;
  logic                 cl_d, cl_q;

  // Both hidden neurons share 20*(x1+x2); NAND is simply its negation plus a larger bias.
  always_comb begin
    xw_s = mul_w(SW'(bus.x1) + SW'(bus.x2));
    hw_s = mul_w(SW'({1'b0, h1_s}) + SW'({1'b0, h2_s}));
    if (bus.en) begin
      zh1_d = sat_q(xw_s + BH1_Q);
      zh2_d = sat_q(BH2_Q - xw_s);
      zo_d  = sat_q(hw_s + BO_Q);
      cl_d  = (y_s >= CL_THRESH);
    end else begin
      zh1_d = zh1_q;
      zh2_d = zh2_q;
      zo_d  = zo_q;
      cl_d  = cl_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zh1_q <= 16'sd0;
      zh2_q <= 16'sd0;
      zo_q  <= 16'sd0;
      cl_q  <= 1'b0;
    end else begin
      zh1_q <= zh1_d;
      zh2_q <= zh2_d;
      zo_q  <= zo_d;
      cl_q  <= cl_d;
    end
  end

  nn_sigmoid u_sig_h1 (.clk(clk), .rst(rst), .en(bus.en), .x(zh1_q), .y(h1_s));
  nn_sigmoid u_sig_h2 (.clk(clk), .rst(rst), .en(bus.en), .x(zh2_q), .y(h2_s));
  nn_sigmoid u_sig_y  (.clk(clk), .rst(rst), .en(bus.en), .x(zo_q),  .y(y_s));

  assign bus.cl = cl_q;

endmodule

// File: tb/tb_xor_nn_core.sv
// Self-checking bench for xor_nn_core: directed traces, enable stalls, resets and random
// samples checked against an integer reference of the network.
module tb_xor_nn_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xor_nn_if bus ();
  xor_nn_core dut (.clk(clk), .rst(rst), .bus(bus));

  logic               sig_en;
  logic signed [15:0] sig_x;
  logic        [15:0] sig_y;
  nn_sigmoid u_sig (.clk(clk), .rst(rst), .en(sig_en), .x(sig_x), .y(sig_y));

  int total = 0;
  int bad   = 0;
  int hist[$];
  int last_exp;
  bit have_exp;

  function automatic int ref_sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  function automatic int ref_sig(input int v);
    int a;
    int f;
    a = (v < 0) ? -v : v;
    if (a >= 5120)      f = 1024;
    else if (a >= 2432) f = a / 32 + 864;
    else if (a >= 1024) f = a / 8 + 640;
    else                f = a / 4 + 512;
    return (v < 0) ? 1024 - f : f;
  endfunction

  function automatic int ref_cl(input int a, input int b);
    int h1;
    int h2;
    int y;
    h1 = ref_sig(ref_sat(20 * a + 20 * b - 10240));
    h2 = ref_sig(ref_sat(-20 * a - 20 * b + 30720));
    y  = ref_sig(ref_sat(20 * h1 + 20 * h2 - 30720));
    return (y >= 512) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
    total++;
    assert (got === 32'(exp)) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock of the main pipeline; a sample's class appears 5 enabled edges after it was taken.
  task automatic step(input logic e, input int a, input int b);
    bus.en = e;
    bus.x1 = 16'(a);
    bus.x2 = 16'(b);
    @(posedge clk);
    #1;
    if (e) begin
      hist.push_back(ref_cl(a, b));
      if (hist.size() == 5) begin
        last_exp = hist.pop_front();
        have_exp = 1'b1;
        chk("stream_cl", bus.cl, last_exp);
      end
    end else if (have_exp) begin
      chk("stall_hold_cl", bus.cl, last_exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_cl", bus.cl, 0);
    end
    rst = 1'b0;
    hist.delete();
    have_exp = 1'b0;
  endtask

  // After a reset the fill values give cl = 0 on enabled edges 1, 3 and 4 and the sample on edge 5.
  task automatic trace(input int a, input int b, input int ezh1, input int ezh2, input int eh1,
                       input int eh2, input int ezo, input int ey, input int ecl);
    do_reset(1);
    step(1'b1, a, b);
    chk("trace_zh1", dut.zh1_q, ezh1);
    chk("trace_zh2", dut.zh2_q, ezh2);
    chk("lat_cl_e1", bus.cl, 0);
    step(1'b1, 0, 0);
    chk("trace_h1", dut.h1_s, eh1);
    chk("trace_h2", dut.h2_s, eh2);
    step(1'b1, 0, 0);
    chk("trace_zo", dut.zo_q, ezo);
    chk("lat_cl_e3", bus.cl, 0);
    step(1'b1, 0, 0);
    chk("trace_y", dut.y_s, ey);
    chk("lat_cl_e4", bus.cl, 0);
    step(1'b1, 0, 0);
    chk("trace_cl", bus.cl, ecl);
  endtask

  int sx[9]  = '{0, 1024, -1024, 2432, -2432, 5120, -5120, 32767, -32767};
  int sy[9]  = '{512, 768, 256, 940, 84, 1024, 0, 1024, 0};
  int corner_a[4] = '{0, 1024, 0, 1024};
  int corner_b[4] = '{0, 0, 1024, 1024};

  initial begin
    int a;
    int b;
    int held;
    logic e;
    bus.en = 1'b0;
    bus.x1 = 16'sd0;
    bus.x2 = 16'sd0;
    sig_en = 1'b0;
    sig_x  = 16'sd0;
    have_exp = 1'b0;

    do_reset(3);
    chk("rst_zh1", dut.zh1_q, 0);
    chk("rst_zh2", dut.zh2_q, 0);
    chk("rst_h1", dut.h1_s, 0);
    chk("rst_h2", dut.h2_s, 0);
    chk("rst_zo", dut.zo_q, 0);
    chk("rst_y", dut.y_s, 0);

    trace(0, 0, -10240, 30720, 0, 1024, -10240, 0, 0);
    trace(1024, 0, 10240, 10240, 1024, 1024, 10240, 1024, 1);
    trace(0, 1024, 10240, 10240, 1024, 1024, 10240, 1024, 1);
    trace(1024, 1024, 30720, -10240, 1024, 0, -10240, 0, 0);
    trace(743, 819, 21000, -520, 1024, 382, -2600, 79, 0);

    // Corners back-to-back with a 3-cycle stall after the first two; garbage on x while stalled.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int k = 0; k < 3; k++) step(1'b0, 5000, -7000);
      end
      step(1'b1, corner_a[i], corner_b[i]);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        for (int k = 0; k < 3; k++) step(1'b0, -3000, 2000);
      end
      step(1'b1, 0, 0);
    end

    for (int i = 0; i < 300; i++) begin
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        a = int'($urandom_range(0, 4096)) - 1536;
        b = int'($urandom_range(0, 4096)) - 1536;
      end else begin
        a = int'($urandom_range(0, 65535)) - 32768;
        b = int'($urandom_range(0, 65535)) - 32768;
      end
      if (i == 150) do_reset(1);
      step(e, a, b);
    end

    // Direct sigmoid checks at the breakpoints and saturation limits.
    bus.en = 1'b0;
    sig_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sig_x = 16'(sx[i]);
      @(posedge clk);
      #1;
      chk("sig_table", sig_y, sy[i]);
    end
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(0, 65534)) - 32767;
      sig_x = 16'(a);
      @(posedge clk);
      #1;
      chk("sig_rand", sig_y, ref_sig(a));
    end
    held = ref_sig(a);
    sig_en = 1'b0;
    sig_x  = 16'sd3000;
    @(posedge clk);
    #1;
    chk("sig_en_hold", sig_y, held);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
